ifm_sparse_loader: RTL and testbench
====================================

Name: ifm_sparse_loader

Overview:
- Upstream feeder of the IFM chunk memory.
- Accepts dense IFM bytes one bus beat at a time over a valid/ready handshake.
- Compresses each beat into a sparsemap plus packed nonzero bytes, then issues registered writes carrying beat (dat) and chunk indices.
- Tracks chunk occupancy against consumer releases, back-pressuring the source when every chunk slot holds unconsumed data.

Parameters:
- BUS_SIZE, 8, bytes per beat; also sparsemap bits per beat.
- CHUNK_SIZE, 32, bytes per chunk; must be a multiple of BUS_SIZE.
- SRAM_IFM_NUM, 4, chunk slots in the IFM memory; power of two, at least 2.
- WR_DAT_CYC_NUM, CHUNK_SIZE/BUS_SIZE, beats per chunk; derived, at least 2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- in_data_i  in  BUS_SIZE x 8  dense input beat; lane k = byte k.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  loader can accept a beat.
- wr_sparsemap_o  out  BUS_SIZE  bit k = 1 iff input lane k was nonzero.
- wr_nonzero_data_o  out  BUS_SIZE x 8  packed nonzero bytes.
- wr_valid_o  out  1  write strobe to the IFM memory.
- wr_dat_count_o  out  clog2(WR_DAT_CYC_NUM)  beat index within the chunk.
- wr_chunk_count_o  out  clog2(SRAM_IFM_NUM)  destination chunk slot.
- chunk_done_o  out  1  pulse when the last beat of a chunk is written.
- chunk_release_i  in  1  consumer finished the oldest full chunk.
- rd_chunk_o  out  clog2(SRAM_IFM_NUM)  oldest full chunk slot.
- chunk_avail_o  out  1  at least one full chunk is present.

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - Clears all registers.
  - wr_valid_o, chunk_done_o, chunk_avail_o = 0.
  - All counts, rd_chunk_o, wr_sparsemap_o and wr_nonzero_data_o = 0.
  - in_ready_o = 1 after reset deasserts.
  - Reset mid-chunk discards the partial chunk and all occupancy.
- Accept: a beat is accepted on a rising edge where in_valid_i && in_ready_o.
- in_ready_o is driven from registers only: in_ready_o = (full_cnt != SRAM_IFM_NUM).
- Compression is combinational on in_data_i and registered at accept:
  - sparsemap[k] = (in_data_i[k] != 0).
  - Output lane m holds the m-th nonzero input byte in ascending lane order.
  - Lanes at or above popcount are 0x00.
- Latency: a beat accepted at edge N gives wr_valid_o = 1 for exactly one cycle after edge N, with its compressed data and the dat/chunk position the beat was accepted at. wr_valid_o = 0 in cycles with no accept. Outputs hold their last values while wr_valid_o = 0.
- Write position counters (advance on accept only):
  - dat_cnt: 0 to WR_DAT_CYC_NUM-1, wraps to 0.
  - On that wrap, chunk_cnt advances 0 to SRAM_IFM_NUM-1, wrapping to 0.
- full_cnt (0 to SRAM_IFM_NUM):
  - +1 at accept of a beat with dat_cnt = WR_DAT_CYC_NUM-1.
  - -1 on chunk_release_i when full_cnt > 0.
  - Both in the same edge: unchanged.
  - chunk_release_i with full_cnt = 0 is ignored; rd_chunk_o does not move.
- rd_chunk_o advances (mod SRAM_IFM_NUM) on each effective release.
- chunk_avail_o = (full_cnt != 0), registered.
- chunk_done_o = 1 in the same cycle as wr_valid_o for the beat with wr_dat_count_o = WR_DAT_CYC_NUM-1.
- Full: in_ready_o = 0 while full_cnt = SRAM_IFM_NUM. A release re-raises in_ready_o the following cycle.
- Invariant: chunk_cnt == (rd_chunk_o + full_cnt) mod SRAM_IFM_NUM whenever dat_cnt = 0.
- Two-state FSM:
  - FILL: in_ready_o = 1.
  - FULL: in_ready_o = 0.
  - FILL to FULL when full_cnt reaches SRAM_IFM_NUM.
  - FULL to FILL on an effective release.
- Data is not checked while in_valid_i = 0.

Test Plan:
- Compression: beat lanes 0..7 = {00,05,00,00,A3,00,00,11} -> next cycle wr_valid_o = 1, wr_sparsemap_o = 8'b1001_0010, nonzero lanes 0..2 = 05,A3,11, lanes 3..7 = 00, dat 0, chunk 0.
- Edge beats:
  - All-zero beat -> sparsemap 0x00, all lanes 00.
  - All-nonzero beat 01..08 -> sparsemap 0xFF, lanes unchanged.
- Wrap: 16 back-to-back beats -> dat counts 0,1,2,3 repeating; chunk counts 0,0,0,0,1,1,1,1,2,...,3; chunk_done_o on beats 4, 8, 12, 16.
- Full/backpressure, no releases:
  - in_ready_o drops the cycle after the 16th accept; full_cnt = 4, chunk_avail_o = 1.
  - A 17th beat held valid is not accepted.
  - One release -> rd_chunk_o = 1, in_ready_o = 1 next cycle, 17th beat written to chunk 0, dat 0.
- Simultaneous events, with full_cnt = 2:
  - Last-beat accept plus release in the same edge -> full_cnt stays 2, rd_chunk_o +1.
  - Release with full_cnt = 0 -> no change.
- Reset mid-chunk: reset after 2 beats of chunk 1 -> all outputs 0, in_ready_o = 1; next beat written to dat 0, chunk 0.

Source files
------------

// File: rtl/ifm_sparse_loader.sv
// ifm_sparse_loader: packs dense IFM beats into sparsemap + nonzero bytes
// and writes them chunk by chunk, tracking occupancy against releases.
module ifm_sparse_loader #(
    parameter  int BUS_SIZE       = 8,
    parameter  int CHUNK_SIZE     = 32,
    parameter  int SRAM_IFM_NUM   = 4,
    localparam int WR_DAT_CYC_NUM = CHUNK_SIZE / BUS_SIZE,
    localparam int DW             = $clog2(WR_DAT_CYC_NUM),
    localparam int CW             = $clog2(SRAM_IFM_NUM),
    localparam int IW             = $clog2(BUS_SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [BUS_SIZE*8-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
    output logic                  wr_valid_o,
    output logic [DW-1:0]         wr_dat_count_o,
    output logic [CW-1:0]         wr_chunk_count_o,
    output logic                  chunk_done_o,
    input  logic                  chunk_release_i,
    output logic [CW-1:0]         rd_chunk_o,
    output logic                  chunk_avail_o
);

    typedef enum logic {FILL, FULL} state_t;

    localparam logic [CW:0]   FULL_LVL = (CW+1)'(SRAM_IFM_NUM);
    localparam logic [DW-1:0] LAST_DAT = DW'(WR_DAT_CYC_NUM - 1);

    state_t                state;
    state_t                state_nxt;
    logic [DW-1:0]         dat_cnt;
    logic [CW-1:0]         chunk_cnt;
    logic [CW:0]           full_cnt;
    logic [CW:0]           full_nxt;
    logic                  accept;
    logic                  last_beat;
    logic                  rel_eff;
    logic [BUS_SIZE-1:0]   map;
    logic [7:0]            lane [BUS_SIZE];
    logic [BUS_SIZE*8-1:0] packed_data;
    logic [IW-1:0]         slot;

    assign in_ready_o = (state == FILL);
    assign accept     = in_valid_i && in_ready_o;
    assign last_beat  = (dat_cnt == LAST_DAT);
    assign rel_eff    = chunk_release_i && (full_cnt != '0);

    // Nonzero bytes are compacted toward lane 0 in ascending input order.
    always_comb begin
        slot        = '0;
        map         = '0;
        packed_data = '0;
        for (int m = 0; m < BUS_SIZE; m++) begin
            lane[m] = 8'h00;
        end
        for (int k = 0; k < BUS_SIZE; k++) begin
            map[k] = (in_data_i[k*8 +: 8] != 8'h00);
            if (map[k]) begin
                lane[slot] = in_data_i[k*8 +: 8];
                slot       = slot + IW'(1);
            end
        end
        for (int m = 0; m < BUS_SIZE; m++) begin
            packed_data[m*8 +: 8] = lane[m];
        end
    end

    always_comb begin
        full_nxt  = full_cnt;
        state_nxt = state;
        case ({accept && last_beat, rel_eff})
            2'b10:   full_nxt = full_cnt + (CW+1)'(1);
            2'b01:   full_nxt = full_cnt - (CW+1)'(1);
            default: full_nxt = full_cnt;
        endcase
        unique case (state)
            FILL: if (full_nxt == FULL_LVL) state_nxt = FULL;
            FULL: if (rel_eff) state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state             <= FILL;
            dat_cnt           <= '0;
            chunk_cnt         <= '0;
            full_cnt          <= '0;
            rd_chunk_o        <= '0;
            chunk_avail_o     <= 1'b0;
            wr_valid_o        <= 1'b0;
            chunk_done_o      <= 1'b0;
            wr_sparsemap_o    <= '0;
            wr_nonzero_data_o <= '0;
            wr_dat_count_o    <= '0;
            wr_chunk_count_o  <= '0;
        end else begin
            state         <= state_nxt;
            full_cnt      <= full_nxt;
            chunk_avail_o <= (full_nxt != '0);
            wr_valid_o    <= accept;
            chunk_done_o  <= accept && last_beat;
            if (accept) begin
                wr_sparsemap_o    <= map;
                wr_nonzero_data_o <= packed_data;
                wr_dat_count_o    <= dat_cnt;
                wr_chunk_count_o  <= chunk_cnt;
                dat_cnt           <= last_beat ? '0 : dat_cnt + DW'(1);
                if (last_beat) begin
                    chunk_cnt <= chunk_cnt + CW'(1);
                end
            end
            if (rel_eff) begin
                rd_chunk_o <= rd_chunk_o + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifm_sparse_loader.sv
// tb_ifm_sparse_loader: directed and randomized checks of the sparse loader
// against a beat-counting reference model.
module tb_ifm_sparse_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  map;
    logic [63:0] nz;
    logic        wr_valid;
    logic [1:0]  dat;
    logic [1:0]  chk;
    logic        done;
    logic        release_r = 1'b0;
    logic [1:0]  rd;
    logic        avail;

    int errs = 0;
    int checks = 0;

    // reference model state
    int n_acc, n_rel, m_full;
    logic        e_valid, e_done, e_avail, e_ready;
    logic [7:0]  e_map;
    logic [63:0] e_nz;
    logic [1:0]  e_dat, e_chunk, e_rd;

    ifm_sparse_loader dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .in_data_i         (in_data),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .wr_sparsemap_o    (map),
        .wr_nonzero_data_o (nz),
        .wr_valid_o        (wr_valid),
        .wr_dat_count_o    (dat),
        .wr_chunk_count_o  (chk),
        .chunk_done_o      (done),
        .chunk_release_i   (release_r),
        .rd_chunk_o        (rd),
        .chunk_avail_o     (avail)
    );

    always #5 clk = ~clk;

    function automatic void compress(input logic [63:0] d,
                                     output logic [7:0] m,
                                     output logic [63:0] z);
        byte unsigned q[$];
        m = '0;
        z = '0;
        for (int k = 0; k < 8; k++) begin
            byte unsigned b;
            b = d[k*8 +: 8];
            m[k] = (b != 0);
            if (b != 0) q.push_back(b);
        end
        for (int i = 0; i < q.size(); i++) z[i*8 +: 8] = q[i];
    endfunction

    function automatic logic [63:0] rnd_beat();
        logic [63:0] d;
        for (int k = 0; k < 8; k++) begin
            d[k*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
        end
        return d;
    endfunction

    task automatic model_clear();
        n_acc = 0; n_rel = 0; m_full = 0;
        e_valid = 0; e_done = 0; e_map = '0; e_nz = '0;
        e_dat = '0; e_chunk = '0; e_rd = '0; e_avail = 0; e_ready = 1;
    endtask

    // one clock: drive at posedge+1, let the model predict, sample at posedge+1
    task automatic step(input logic v, input logic [63:0] d, input logic r);
        logic acc;
        int   fb;
        in_valid  = v;
        in_data   = d;
        release_r = r;
        fb  = m_full;
        acc = v && (fb != 4);
        @(posedge clk);
        #1;
        e_valid = acc;
        e_done  = 1'b0;
        if (acc) begin
            compress(d, e_map, e_nz);
            e_dat   = 2'(n_acc % 4);
            e_chunk = 2'((n_acc / 4) % 4);
            e_done  = (n_acc % 4 == 3);
            if (n_acc % 4 == 3) m_full++;
            n_acc++;
        end
        if (r && fb > 0) begin
            m_full--;
            n_rel++;
        end
        e_rd    = 2'(n_rel % 4);
        e_avail = (m_full != 0);
        e_ready = (m_full != 4);
        in_valid  = 1'b0;
        release_r = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 0;
        release_r = 0;
        rst = 0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({wr_valid, done, dat, chk, map, nz, rd, avail} !== '0) begin
            errs++;
            $display("FAIL reset_outs got %h exp 0",
                     {wr_valid, done, dat, chk, map, nz, rd, avail});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_compress();
        logic [63:0] beats [3];
        logic [7:0]  maps  [3];
        logic [63:0] nzs   [3];
        beats[0] = 64'h1100_00A3_0000_0500;
        maps[0]  = 8'b1001_0010;
        nzs[0]   = 64'h0000_0000_0011_A305;
        beats[1] = 64'h0;
        maps[1]  = 8'h00;
        nzs[1]   = 64'h0;
        beats[2] = 64'h0807_0605_0403_0201;
        maps[2]  = 8'hFF;
        nzs[2]   = 64'h0807_0605_0403_0201;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, beats[i], 1'b0);
            checks++;
            if ({wr_valid, map, nz} !== {1'b1, maps[i], nzs[i]}) begin
                errs++;
                $display("FAIL compress%0d got %b %h %h exp 1 %h %h",
                         i, wr_valid, map, nz, maps[i], nzs[i]);
            end
            checks++;
            if ({dat, chk} !== {2'(i), 2'd0}) begin
                errs++;
                $display("FAIL compress_pos%0d got %0d/%0d exp %0d/0",
                         i, dat, chk, i);
            end
        end
        step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        checks++;
        if ({wr_valid, map, nz} !== {1'b0, maps[2], nzs[2]}) begin
            errs++;
            $display("FAIL compress_hold got %b %h %h exp 0 %h %h",
                     wr_valid, map, nz, maps[2], nzs[2]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, rnd_beat(), 1'b0);
            checks++;
            if ({wr_valid, done, dat, chk} !==
                {1'b1, (i % 4 == 3), 2'(i % 4), 2'(i / 4)}) begin
                errs++;
                $display("FAIL wrap%0d got v%b d%b %0d/%0d exp done %0d pos %0d/%0d",
                         i, wr_valid, done, dat, chk, i % 4 == 3, i % 4, i / 4);
            end
        end
        checks++;
        if ({in_ready, avail} !== 2'b01) begin
            errs++;
            $display("FAIL wrap_full got ready %b avail %b exp 0 1",
                     in_ready, avail);
        end
    endtask

    task automatic test_full();
        logic [63:0] d17;
        d17 = rnd_beat();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, d17, 1'b0);
            checks++;
            if ({wr_valid, in_ready} !== 2'b00) begin
                errs++;
                $display("FAIL full_block%0d got valid %b ready %b exp 0 0",
                         i, wr_valid, in_ready);
            end
        end
        step(1'b1, d17, 1'b1);
        checks++;
        if ({wr_valid, in_ready, rd} !== {1'b0, 1'b1, 2'd1}) begin
            errs++;
            $display("FAIL full_release got valid %b ready %b rd %0d exp 0 1 1",
                     wr_valid, in_ready, rd);
        end
        step(1'b1, d17, 1'b0);
        checks++;
        if ({wr_valid, dat, chk, map, nz} !==
            {1'b1, 2'd0, 2'd0, e_map, e_nz}) begin
            errs++;
            $display("FAIL full_17th got v%b %0d/%0d %h %h exp 1 0/0 %h %h",
                     wr_valid, dat, chk, map, nz, e_map, e_nz);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 11; i++) step(1'b1, rnd_beat(), 1'b0);
        step(1'b1, rnd_beat(), 1'b1);
        checks++;
        if ({done, rd, avail, in_ready} !== {1'b1, 2'd1, 1'b1, 1'b1}) begin
            errs++;
            $display("FAIL simul_edge got done %b rd %0d avail %b ready %b exp 1 1 1 1",
                     done, rd, avail, in_ready);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if ({rd, avail} !== {2'd2, 1'b1}) begin
            errs++;
            $display("FAIL simul_rel1 got rd %0d avail %b exp 2 1", rd, avail);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if ({rd, avail} !== {2'd3, 1'b0}) begin
            errs++;
            $display("FAIL simul_rel2 got rd %0d avail %b exp 3 0", rd, avail);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if ({rd, avail, in_ready} !== {2'd3, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL simul_empty_rel got rd %0d avail %b ready %b exp 3 0 1",
                     rd, avail, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, rnd_beat(), 1'b0);
        #2;
        rst = 0;
        model_clear();
        #1;
        checks++;
        if ({wr_valid, done, dat, chk, map, nz, rd, avail, in_ready} !==
            {81'd0, 1'b1}) begin
            errs++;
            $display("FAIL reset_mid got %h exp 1",
                     {wr_valid, done, dat, chk, map, nz, rd, avail, in_ready});
        end
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        step(1'b1, rnd_beat(), 1'b0);
        checks++;
        if ({wr_valid, dat, chk} !== {1'b1, 2'd0, 2'd0}) begin
            errs++;
            $display("FAIL reset_mid_next got v%b %0d/%0d exp 1 0/0",
                     wr_valid, dat, chk);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, rnd_beat(), $urandom_range(0, 9) < 3);
            checks++;
            if ({wr_valid, done, dat, chk, map, nz, rd, avail, in_ready} !==
                {e_valid, e_done, e_dat, e_chunk, e_map, e_nz, e_rd,
                 e_avail, e_ready}) begin
                errs++;
                $display("FAIL random%0d got %h exp %h", i,
                         {wr_valid, done, dat, chk, map, nz, rd, avail, in_ready},
                         {e_valid, e_done, e_dat, e_chunk, e_map, e_nz, e_rd,
                          e_avail, e_ready});
            end
        end
    endtask

    initial begin
        model_clear();
        #3;
        test_reset();
        test_compress();
        test_wrap();
        test_full();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
